// File: rtl/buffer_unidad_fifo.sv
// buffer_unidad_fifo: single-clock circular FIFO used by the row-buffer stage
// of the filter. It holds 8-bit pixel samples and presents the oldest one on
// data_out without a read (first-word-fall-through).
//
// Handshake: a write is accepted on a rising edge when
// write_req & write_en & ~fifo_full. A read (pop) is accepted when
// read_req & read_en & ~fifo_empty. Both conditions use the state from before
// the edge. Requests are level-sampled, so holding one high performs one
// operation per cycle. A rejected request has no effect and raises no error.
// buffer_change pulses for the cycle after any accepted operation.
module buffer_unidad_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_req,
  input  logic                  write_en,
  input  logic                  read_req,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic [ADDR_WIDTH-1:0] data_in_buffer,
  output logic                  buffer_change
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // One slot stays unused, so the largest count fits exactly in ADDR_WIDTH bits.
  localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = '1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic                  change_q, change_d;
  logic                  wr_acc, rd_acc;

  assign fifo_empty     = (count_q == '0);
  assign fifo_full      = (count_q == MAX_COUNT);
  assign data_in_buffer = count_q;
  assign buffer_change  = change_q;
  assign data_out       = fifo_empty ? '0 : mem_q[rd_ptr_q];

  assign wr_acc = write_req & write_en & ~fifo_full;
  assign rd_acc = read_req  & read_en  & ~fifo_empty;

  // Next-state for the pointers, the occupancy count and the change strobe.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    change_d = wr_acc | rd_acc;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    // A simultaneous write and read leaves the count unchanged.
    if (wr_acc && !rd_acc)      count_d = count_q + PTR_ONE;
    else if (rd_acc && !wr_acc) count_d = count_q - PTR_ONE;
  end

  // Control registers with asynchronous reset. Storage is not cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      change_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      change_q <= change_d;
    end
  end

  // Sample storage. Stale words become unreachable after reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_buffer_unidad_fifo.sv
// tb_buffer_unidad_fifo: scoreboard bench for the row-buffer FIFO.
module tb_buffer_unidad_fifo;

  localparam int W     = 8;
  localparam int AW    = 3;
  localparam int MAXC  = 7;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  data_in;
  logic          write_req, write_en, read_req, read_en;
  logic [W-1:0]  data_out;
  logic          fifo_full, fifo_empty;
  logic [AW-1:0] data_in_buffer;
  logic          buffer_change;

  always #5 clk = ~clk;

  buffer_unidad_fifo #(.DATA_WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .data_in        (data_in),
    .write_req      (write_req),
    .write_en       (write_en),
    .read_req       (read_req),
    .read_en        (read_en),
    .data_out       (data_out),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .data_in_buffer (data_in_buffer),
    .buffer_change  (buffer_change)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         exp_change;
  int           tests_run = 0;
  int           tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [W-1:0] exp_head;
    exp_head = (exp_q.size() != 0) ? exp_q[0] : '0;
    check_eq({tag, ".data_out"}, 32'(data_out), 32'(exp_head));
    check_eq({tag, ".count"},    32'(data_in_buffer), 32'(exp_q.size()));
    check_eq({tag, ".empty"},    32'(fifo_empty), 32'(exp_q.size() == 0));
    check_eq({tag, ".full"},     32'(fifo_full), 32'(exp_q.size() == MAXC));
    check_eq({tag, ".change"},   32'(buffer_change), 32'(exp_change));
  endtask

  // ---------------- driver ----------------
  // Drives one cycle away from the edge, predicts acceptance from the
  // pre-edge model, then checks just after the edge.
  task automatic step(input string tag, input logic wr, input logic we,
                      input logic rd, input logic re, input logic [W-1:0] din);
    logic wa, ra;
    data_in   = din;
    write_req = wr;
    write_en  = we;
    read_req  = rd;
    read_en   = re;
    wa = wr & we & (exp_q.size() != MAXC);
    ra = rd & re & (exp_q.size() != 0);
    @(posedge clk);
    #1;
    if (ra) void'(exp_q.pop_front());
    if (wa) exp_q.push_back(din);
    exp_change = wa | ra;
    check_outputs(tag);
    write_req = 1'b0;
    read_req  = 1'b0;
  endtask

  task automatic push(input string tag, input logic [W-1:0] din);
    step(tag, 1'b1, 1'b1, 1'b0, 1'b1, din);
  endtask

  task automatic pop(input string tag);
    step(tag, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] seq [9];
    seq = '{8'd128, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};

    reset = 1'b1;
    data_in = '0;
    write_req = 1'b0; write_en = 1'b1;
    read_req  = 1'b0; read_en  = 1'b1;
    exp_change = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // Idle holds reset values.
    repeat (3) idle("idle");

    // Single push, strobe then drops.
    push("push128", 8'd128);
    idle("push128_after");
    pop("drain1");
    idle("drain1_after");

    // Nine pushes: last two rejected while full.
    for (int i = 0; i < 9; i++) push($sformatf("fill%0d", i), seq[i]);

    // Pop until empty, plus one extra pop on empty.
    for (int i = 0; i < 8; i++) pop($sformatf("pop%0d", i));
    idle("empty_idle");

    // Enable gating.
    push("gate_seed0", 8'hA5);
    push("gate_seed1", 8'h5A);
    step("gate_wr_en0", 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF);
    step("gate_rd_en0", 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);

    // Simultaneous push/pop with 3 entries.
    push("simul_seed", 8'h33);
    step("simul", 1'b1, 1'b1, 1'b1, 1'b1, 8'h44);
    step("simul2", 1'b1, 1'b1, 1'b1, 1'b1, 8'h55);

    // Simultaneous on full and on empty.
    while (exp_q.size() < MAXC) push("tofull", 8'($urandom_range(0, 255)));
    step("simul_full", 1'b1, 1'b1, 1'b1, 1'b1, 8'h99);
    while (exp_q.size() > 0) pop("toempty");
    step("simul_empty", 1'b1, 1'b1, 1'b1, 1'b1, 8'h77);

    // Async reset mid-cycle with 5 entries.
    while (exp_q.size() < 5) push("pre_rst", 8'($urandom_range(0, 255)));
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    exp_change = 1'b0;
    check_outputs("async_rst");
    @(negedge clk);
    reset = 1'b0;
    push("post_rst", 8'h3C);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      step("rand",
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           8'($urandom_range(0, 255)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
